// File: rtl/bus_bridge_remote_uart_requester.sv
// Remote end of the UART bus bridge: serialises one bus request as four bytes and collects the two-byte reply.
// Optional reply timeout is enabled with the BRIDGE_RESP_TIMEOUT_EN macro (RESP_TIMEOUT_CYCLES sets its length).
module bus_bridge_remote_uart_requester #(
  parameter int unsigned RESP_TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  input  logic        req_is_write,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [7:0]  resp_rdata,
  output logic        resp_is_write,
  output logic        resp_err,
  output logic        busy,
  output logic [7:0]  uart_data_in,
  output logic        uart_wr_en,
  input  logic        uart_tx_busy,
  input  logic        uart_ready,
  output logic        uart_ready_clr,
  input  logic [7:0]  uart_data_out
);

  typedef enum logic [3:0] {
    IDLE, SEND_AL, WAIT_AL, SEND_AH, WAIT_AH, SEND_WD, WAIT_WD,
    SEND_FL, WAIT_FL, RX_RD, RX_FL, RESP
  } state_t;

  state_t      state, state_d;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic        is_write_q;
  logic        tx_busy_q;
  logic        rx_ready_q;
  logic        tx_done;
  logic        rx_pulse;
  logic        tmo_hit;

  logic        tx_fire;
  logic [7:0]  tx_byte;
  logic        rx_rd_take;
  logic        rx_fl_take;
  logic        tmo_fire;
  logic        resp_take;

  logic        unused_cfg;
  assign unused_cfg = (RESP_TIMEOUT_CYCLES > 0);

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign tx_done   = tx_busy_q && !uart_tx_busy;
  assign rx_pulse  = uart_ready && !rx_ready_q;

`ifdef BRIDGE_RESP_TIMEOUT_EN
  localparam int unsigned TMO_W = (RESP_TIMEOUT_CYCLES > 2) ? $clog2(RESP_TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RESP_TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt;

  // Counts idle cycles between reply bytes; held at zero outside the receive states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (((state != RX_RD) && (state != RX_FL)) || rx_pulse) begin
      tmo_cnt <= '0;
    end else if (!tmo_hit) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign tmo_hit = (tmo_cnt == TMO_LAST);
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d    = state;
    tx_fire    = 1'b0;
    tx_byte    = 8'h00;
    rx_rd_take = 1'b0;
    rx_fl_take = 1'b0;
    tmo_fire   = 1'b0;
    resp_take  = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) state_d = SEND_AL;
      end
      SEND_AL: begin
        if (!uart_tx_busy) begin
          tx_fire = 1'b1;
          tx_byte = addr_q[7:0];
          state_d = WAIT_AL;
        end
      end
      WAIT_AL: if (tx_done) state_d = SEND_AH;
      SEND_AH: begin
        if (!uart_tx_busy) begin
          tx_fire = 1'b1;
          tx_byte = addr_q[15:8];
          state_d = WAIT_AH;
        end
      end
      WAIT_AH: if (tx_done) state_d = SEND_WD;
      SEND_WD: begin
        if (!uart_tx_busy) begin
          tx_fire = 1'b1;
          tx_byte = wdata_q;
          state_d = WAIT_WD;
        end
      end
      WAIT_WD: if (tx_done) state_d = SEND_FL;
      SEND_FL: begin
        if (!uart_tx_busy) begin
          tx_fire = 1'b1;
          tx_byte = {7'b0, is_write_q};
          state_d = WAIT_FL;
        end
      end
      WAIT_FL: if (tx_done) state_d = RX_RD;
      RX_RD: begin
        if (rx_pulse) begin
          rx_rd_take = 1'b1;
          state_d    = RX_FL;
        end else if (tmo_hit) begin
          tmo_fire = 1'b1;
          state_d  = RESP;
        end
      end
      RX_FL: begin
        if (rx_pulse) begin
          rx_fl_take = 1'b1;
          state_d    = RESP;
        end else if (tmo_hit) begin
          tmo_fire = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (resp_valid && resp_ready) begin
          resp_take = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
    end else if (req_valid && req_ready) begin
      addr_q     <= req_addr;
      wdata_q    <= req_wdata;
      is_write_q <= req_is_write;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy_q  <= 1'b0;
      rx_ready_q <= 1'b0;
    end else begin
      tx_busy_q  <= uart_tx_busy;
      rx_ready_q <= uart_ready;
    end
  end

  // Every received byte is acknowledged; bytes outside the receive states are simply not latched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uart_wr_en     <= 1'b0;
      uart_data_in   <= '0;
      uart_ready_clr <= 1'b0;
    end else begin
      uart_wr_en     <= tx_fire;
      uart_ready_clr <= rx_pulse;
      if (tx_fire) uart_data_in <= tx_byte;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_is_write <= 1'b0;
      resp_err      <= 1'b0;
    end else begin
      if (rx_rd_take) resp_rdata <= uart_data_out;
      if (rx_fl_take) begin
        resp_is_write <= uart_data_out[0];
        resp_err      <= (uart_data_out[0] != is_write_q);
        resp_valid    <= 1'b1;
      end
      if (tmo_fire) begin
        resp_rdata    <= 8'h00;
        resp_is_write <= is_write_q;
        resp_err      <= 1'b1;
        resp_valid    <= 1'b1;
      end
      if (resp_take) resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bus_bridge_remote_uart_requester.sv
// Scoreboard bench for bus_bridge_remote_uart_requester: expected TX bytes and responses are queued
// at stimulus time and popped by negedge monitors.
module tb_bus_bridge_remote_uart_requester;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        req_is_write = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [7:0]  resp_rdata;
  logic        resp_is_write;
  logic        resp_err;
  logic        busy;
  logic [7:0]  uart_data_in;
  logic        uart_wr_en;
  logic        uart_tx_busy;
  logic        uart_ready = 1'b0;
  logic        uart_ready_clr;
  logic [7:0]  uart_data_out = '0;

  typedef struct packed {
    logic [7:0] rdata;
    logic       w;
    logic       err;
  } resp_t;

  int    n_checks = 0;
  int    n_errors = 0;
  logic [7:0] tx_exp[$];
  resp_t resp_exp[$];
  int    tx_seen = 0;
  int    clr_count = 0;
  int    busy_cnt = 0;

  always #5 clk = ~clk;

`ifdef BRIDGE_RESP_TIMEOUT_EN
  localparam int unsigned TB_TMO_CYCLES = 100;
`else
  localparam int unsigned TB_TMO_CYCLES = 1_000_000;
`endif

  bus_bridge_remote_uart_requester #(.RESP_TIMEOUT_CYCLES(TB_TMO_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_is_write(req_is_write),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_is_write(resp_is_write), .resp_err(resp_err), .busy(busy),
    .uart_data_in(uart_data_in), .uart_wr_en(uart_wr_en), .uart_tx_busy(uart_tx_busy),
    .uart_ready(uart_ready), .uart_ready_clr(uart_ready_clr), .uart_data_out(uart_data_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // UART transmitter model: busy for 10 cycles after each write strobe.
  always @(posedge clk) begin
    if (uart_wr_en) busy_cnt <= 10;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign uart_tx_busy = (busy_cnt != 0);

  always @(negedge clk) begin
    if (uart_wr_en) begin
      tx_seen++;
      if (tx_exp.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL tx_unexpected: got byte %02h, expected no transmit", uart_data_in);
      end else begin
        check("tx_byte", {24'h0, uart_data_in}, {24'h0, tx_exp.pop_front()});
      end
    end
    if (uart_ready_clr) clr_count++;
    if (resp_valid && resp_ready) begin
      if (resp_exp.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL resp_unexpected: got rdata %02h, expected no response", resp_rdata);
      end else begin
        resp_t e;
        e = resp_exp.pop_front();
        check("resp_rdata", {24'h0, resp_rdata}, {24'h0, e.rdata});
        check("resp_is_write", {31'h0, resp_is_write}, {31'h0, e.w});
        check("resp_err", {31'h0, resp_err}, {31'h0, e.err});
        check("req_ready_at_handshake", {31'h0, req_ready}, 32'h0);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_accept();
    bit ok = 0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk);
      if (req_ready) ok = 1;
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout: got req_ready=0, expected 1");
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("busy_after_accept", {31'h0, busy}, 32'h1);
    check("req_ready_after_accept", {31'h0, req_ready}, 32'h0);
  endtask

  task automatic issue(input logic [15:0] a, input logic [7:0] d, input logic w);
    tx_exp.push_back(a[7:0]);
    tx_exp.push_back(a[15:8]);
    tx_exp.push_back(d);
    tx_exp.push_back({7'b0, w});
    req_addr = a;
    req_wdata = d;
    req_is_write = w;
    req_valid = 1'b1;
    wait_accept();
  endtask

  task automatic wait_tx(input int target);
    bit ok = 0;
    for (int k = 0; k < 1000 && !ok; k++) begin
      @(negedge clk);
      if (tx_seen >= target && !uart_tx_busy) ok = 1;
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL tx_wait_timeout: got %0d bytes, expected %0d", tx_seen, target);
    end
    cyc(3);
  endtask

  task automatic inject(input logic [7:0] b);
    bit ok = 0;
    uart_data_out = b;
    uart_ready = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (uart_ready_clr) ok = 1;
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL ready_clr_timeout: got no clear for byte %02h, expected one", b);
    end
    @(posedge clk);
    #1;
    uart_ready = 1'b0;
    cyc(2);
  endtask

  task automatic wait_resp_valid(output int cycles);
    bit ok = 0;
    cycles = 0;
    for (int k = 0; k < 2000 && !ok; k++) begin
      @(negedge clk);
      cycles++;
      if (resp_valid) ok = 1;
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL resp_valid_timeout: got resp_valid=0, expected 1");
    end
  endtask

  task automatic handshake();
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check("resp_valid_after_hs", {31'h0, resp_valid}, 32'h0);
    check("req_ready_after_hs", {31'h0, req_ready}, 32'h1);
  endtask

  task automatic txn(input logic [15:0] a, input logic [7:0] d, input logic w,
                     input logic [7:0] rd, input logic [7:0] fl,
                     input logic [7:0] e_rd, input logic e_w, input logic e_err);
    int base;
    int cyc_n;
    base = tx_seen;
    resp_exp.push_back('{rdata: e_rd, w: e_w, err: e_err});
    issue(a, d, w);
    wait_tx(base + 4);
    inject(rd);
    inject(fl);
    wait_resp_valid(cyc_n);
    handshake();
  endtask

  initial begin
    int base;
    int cyc_n;
    int clr0;
    bit stable_bad;
    bit rr_bad;

    cyc(3);
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_wr_en", {31'h0, uart_wr_en}, 32'h0);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_data_in", {24'h0, uart_data_in}, 32'h0);
    check("rst_ready_clr", {31'h0, uart_ready_clr}, 32'h0);
    rst_n = 1'b1;
    cyc(2);

    // Write, read
    txn(16'h12A5, 8'h3C, 1'b1, 8'h00, 8'h01, 8'h00, 1'b1, 1'b0);
    txn(16'h0040, 8'h99, 1'b0, 8'h7E, 8'h00, 8'h7E, 1'b0, 1'b0);

    // Backpressure with a second request pending
    base = tx_seen;
    resp_exp.push_back('{rdata: 8'hAB, w: 1'b0, err: 1'b0});
    issue(16'h0102, 8'h55, 1'b0);
    wait_tx(base + 4);
    inject(8'hAB);
    inject(8'h00);
    wait_resp_valid(cyc_n);
    @(posedge clk);
    #1;
    tx_exp.push_back(8'hEF);
    tx_exp.push_back(8'hBE);
    tx_exp.push_back(8'h77);
    tx_exp.push_back(8'h01);
    req_addr = 16'hBEEF;
    req_wdata = 8'h77;
    req_is_write = 1'b1;
    req_valid = 1'b1;
    stable_bad = 0;
    rr_bad = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!resp_valid || resp_rdata !== 8'hAB || resp_is_write !== 1'b0 || resp_err !== 1'b0)
        stable_bad = 1;
      if (req_ready) rr_bad = 1;
    end
    check("bp_resp_stable", {31'h0, stable_bad}, 32'h0);
    check("bp_req_ready_low", {31'h0, rr_bad}, 32'h0);
    check("bp_no_early_tx", tx_seen, base + 4);
    resp_exp.push_back('{rdata: 8'h00, w: 1'b1, err: 1'b0});
    handshake();
    base = tx_seen;
    wait_accept();
    wait_tx(base + 4);
    inject(8'h00);
    inject(8'h01);
    wait_resp_valid(cyc_n);
    handshake();

    // Stray byte in IDLE, then a normal read
    clr0 = clr_count;
    inject(8'h5A);
    cyc(2);
    check("stray_clr_once", clr_count - clr0, 32'h1);
    check("stray_busy", {31'h0, busy}, 32'h0);
    check("stray_no_resp", {31'h0, resp_valid}, 32'h0);
    txn(16'h0033, 8'h00, 1'b0, 8'h11, 8'h00, 8'h11, 1'b0, 1'b0);

    // Flag mismatch
    txn(16'h0200, 8'hA1, 1'b1, 8'h22, 8'h00, 8'h22, 1'b0, 1'b1);

    // Reset in WAIT_AH
    base = tx_seen;
    issue(16'h0300, 8'h44, 1'b1);
    for (int k = 0; k < 200 && tx_seen < base + 2; k++) @(negedge clk);
    check("rst_mid_two_bytes", tx_seen, base + 2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    check("mid_rst_wr_en", {31'h0, uart_wr_en}, 32'h0);
    check("mid_rst_data_in", {24'h0, uart_data_in}, 32'h0);
    check("mid_rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    tx_exp.delete();
    cyc(3);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", {31'h0, req_ready}, 32'h1);
    check("post_rst_busy", {31'h0, busy}, 32'h0);
    cyc(20);
    check("post_rst_no_tx", tx_seen, base + 2);
    txn(16'hFFFF, 8'hFF, 1'b0, 8'h5C, 8'h00, 8'h5C, 1'b0, 1'b0);

`ifdef BRIDGE_RESP_TIMEOUT_EN
    base = tx_seen;
    resp_exp.push_back('{rdata: 8'h00, w: 1'b0, err: 1'b1});
    issue(16'h0010, 8'h00, 1'b0);
    wait_tx(base + 4);
    begin
      time t0;
      t0 = $time;
      inject(8'h33);
      wait_resp_valid(cyc_n);
      cyc_n = int'(($time - t0) / 10);
      check("timeout_latency_ok", {31'h0, (cyc_n >= 95 && cyc_n <= 110)}, 32'h1);
    end
    handshake();
`endif

    cyc(5);
    check("tx_queue_empty", tx_exp.size(), 32'h0);
    check("resp_queue_empty", resp_exp.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
